// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, FSM encoding and helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/Ripple_Adder_4bits.sv
// Existing 4-bit ripple-carry adder; purely combinational.
module Ripple_Adder_4bits
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic carry;

   always_comb begin
      carry = cin;
      sum   = '0;
      for (int unsigned i = 0; i < NIBBLE_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit ripple adder reused once per nibble, LSB first,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
   localparam int unsigned IDX_W   = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e             state;
   state_e             state_nxt;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   sum_reg;
   logic               c_reg;
   logic [IDX_W-1:0]   idx;
   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] add_sum;
   logic               add_cout;
   logic               accept;

   assign accept = (state == S_IDLE) && in_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; unused encodings fall back to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)        state_nxt = S_RUN;
         S_RUN:   if (idx == LAST_IDX) state_nxt = S_DONE;
         S_DONE:  if (out_ready)       state_nxt = S_IDLE;
         default:                      state_nxt = S_IDLE;
      endcase
   end

   // Select the active nibble of each operand
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx == IDX_W'(i)) begin
            a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
            b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   Ripple_Adder_4bits u_adder (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (c_reg),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Operand capture and per-nibble accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         c_reg   <= 1'b0;
         idx     <= '0;
      end else if (accept) begin
         a_reg <= in_a;
         b_reg <= in_b;
         c_reg <= in_cin;
         idx   <= '0;
      end else if (state == S_RUN) begin
         for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= add_sum;
         end
         c_reg <= add_cout;
         if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_RUN) || (state == S_DONE);
   assign out_sum   = sum_reg;
   assign out_cout  = c_reg;
   // Carry into the MSB is a^b^sum at that bit; overflow when it differs from carry out
   assign out_ovf   = c_reg ^ (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum_reg[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: 16-bit and 4-bit instances side by side.
module tb_nibble_serial_adder;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
   logic [15:0] in_a, in_b, out_sum;

   logic        v4_in_valid, v4_in_ready, v4_in_cin, v4_out_valid, v4_out_ready;
   logic        v4_out_cout, v4_out_ovf, v4_busy;
   logic [3:0]  v4_in_a, v4_in_b, v4_out_sum;

   int vectors;
   int miscompares;
   int lat;

   nibble_serial_adder #(.WIDTH(16)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   nibble_serial_adder #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v4_in_valid),
      .in_ready  (v4_in_ready),
      .in_a      (v4_in_a),
      .in_b      (v4_in_b),
      .in_cin    (v4_in_cin),
      .out_valid (v4_out_valid),
      .out_ready (v4_out_ready),
      .out_sum   (v4_out_sum),
      .out_cout  (v4_out_cout),
      .out_ovf   (v4_out_ovf),
      .busy      (v4_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue one 16-bit operation, wait for the result and check it, then drain it.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = 1'b1;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat),      32'd4);
      chk({tag, "_sum"},     32'(out_sum),  32'(exp_sum));
      chk({tag, "_cout"},    32'(out_cout), 32'(exp_cout));
      chk({tag, "_ovf"},     32'(out_ovf),  32'(exp_ovf));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_back_idle"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
      v4_in_valid = 1'b0; v4_in_a = '0; v4_in_b = '0; v4_in_cin = 1'b0; v4_out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(out_sum),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // Basic sums, full carry ripple and overflow cases
      do_op("t1",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      do_op("t2",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      do_op("cin", 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);

      // Backpressure in DONE with new operands offered
      in_a = 16'h00FF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("t4_latency", 32'(lat), 32'd4);
      in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_sum",   32'(out_sum),   32'h0100);
         chk("t4_hold_ready", 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_idle_valid", 32'(out_valid), 32'd0);
      chk("t4_idle_busy",  32'(busy),      32'd0);
      chk("t4_idle_ready", 32'(in_ready),  32'd1);

      // Reset in the middle of RUN
      in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_sum",   32'(out_sum),   32'd0);
      chk("t5_cout",  32'(out_cout),  32'd0);
      chk("t5_ovf",   32'(out_ovf),   32'd0);
      chk("t5_busy",  32'(busy),      32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t5_ready", 32'(in_ready), 32'd1);
      do_op("t5_post", 16'h0002, 16'h0003, 1'b1, 16'h0006, 1'b0, 1'b0);

      // Single-nibble instance
      v4_in_a = 4'hF; v4_in_b = 4'h0; v4_in_cin = 1'b1; v4_in_valid = 1'b1;
      chk("t6_in_ready", 32'(v4_in_ready), 32'd1);
      tick();
      v4_in_valid = 1'b0;
      chk("t6_run_valid", 32'(v4_out_valid), 32'd0);
      chk("t6_run_busy",  32'(v4_busy),      32'd1);
      tick();
      chk("t6_valid", 32'(v4_out_valid), 32'd1);
      chk("t6_sum",   32'(v4_out_sum),   32'h0);
      chk("t6_cout",  32'(v4_out_cout),  32'd1);
      chk("t6_ovf",   32'(v4_out_ovf),   32'd0);
      v4_out_ready = 1'b1;
      tick();
      v4_out_ready = 1'b0;
      chk("t6_idle", 32'(v4_in_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
